rename_map: RTL and testbench

RENAME_MAP -- requirements
Module: rename_map

---
 rtl/rename_pkg.sv | 14 +
 rtl/rename_freelist.sv | 86 ++++++++
 rtl/rename_map.sv | 132 +++++++++++++
 tb/tb_rename_map.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Register rename shared types and default sizes.
// Widths here follow the default configuration.
package rename_pkg;

  localparam int ARCH_REGS = 34;
  localparam int PHYS_REGS = 64;
  localparam int ARCH_W = $clog2(ARCH_REGS);
  localparam int PHYS_W = $clog2(PHYS_REGS);

  typedef logic [ARCH_W-1:0] arch_reg_t;
  typedef logic [PHYS_W-1:0] phys_reg_t;
  typedef logic [PHYS_W:0]   fl_ptr_t;

endpackage

// File: rtl/rename_freelist.sv
// Circular free list of physical registers with a speculative
// allocation head, a committed head and a shared tail.
module rename_freelist #(
  parameter int ARCH_REGS = rename_pkg::ARCH_REGS,
  parameter int PHYS_REGS = rename_pkg::PHYS_REGS,
  parameter int REN_W = 2,
  parameter int RET_W = 2,
  localparam int PW = $clog2(PHYS_REGS),
  localparam int CW = $clog2(REN_W + 1)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic                      alloc,
  input  logic [CW-1:0]             alloc_cnt,
  input  logic [RET_W-1:0]          ret_commit,
  input  logic [RET_W-1:0][PW-1:0]  ret_old_dest,
  output logic [REN_W-1:0][PW-1:0]  peek,
  output logic [PW:0]               free_count
);
  import rename_pkg::*;

  localparam int INIT_FREE = PHYS_REGS - ARCH_REGS;
  localparam logic [PW:0] P_ONE = (PW + 1)'(1);

  logic [PW-1:0] mem [PHYS_REGS];
  logic [PW:0] spec_head;
  logic [PW:0] commit_head;
  logic [PW:0] tail;
  logic [PW:0] commit_head_nx;
  logic [PW:0] tail_nx;
  logic [RET_W-1:0] push_en;
  logic [RET_W-1:0][PW:0] push_ptr;

  always_comb begin
    commit_head_nx = commit_head;
    tail_nx = tail;
    push_en = '0;
    push_ptr = '0;
    for (int i = 0; i < RET_W; i++) begin
      if (ret_commit[i]) begin
        commit_head_nx = commit_head_nx + P_ONE;
      end
      // A zero old mapping is the hardwired register, never recycled.
      if (ret_commit[i] && ret_old_dest[i] != '0) begin
        push_en[i] = 1'b1;
        push_ptr[i] = tail_nx;
        tail_nx = tail_nx + P_ONE;
      end
    end
  end

  always_comb begin
    peek = '0;
    for (int i = 0; i < REN_W; i++) begin
      peek[i] = mem[spec_head[PW-1:0] + PW'(i)];
    end
  end

  assign free_count = tail - spec_head;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int j = 0; j < PHYS_REGS; j++) begin
        mem[j] <= (j < INIT_FREE) ? PW'(ARCH_REGS + j) : '0;
      end
      spec_head <= '0;
      commit_head <= '0;
      tail <= (PW + 1)'(INIT_FREE);
    end else begin
      for (int i = 0; i < RET_W; i++) begin
        if (push_en[i]) begin
          mem[push_ptr[i][PW-1:0]] <= ret_old_dest[i];
        end
      end
      commit_head <= commit_head_nx;
      tail <= tail_nx;
      if (flush) begin
        spec_head <= commit_head_nx;
      end else if (alloc) begin
        spec_head <= spec_head + (PW + 1)'(alloc_cnt);
      end
    end
  end

endmodule

// File: rtl/rename_map.sv
// Speculative and committed register alias tables with
// in-group bypass; physical tags come from rename_freelist.
module rename_map #(
  parameter int ARCH_REGS = rename_pkg::ARCH_REGS,
  parameter int PHYS_REGS = rename_pkg::PHYS_REGS,
  parameter int REN_W = 2,
  parameter int RET_W = 2,
  localparam int AW = $clog2(ARCH_REGS),
  localparam int PW = $clog2(PHYS_REGS),
  localparam int CW = $clog2(REN_W + 1)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic                      ren_valid,
  output logic                      ren_ready,
  input  logic [REN_W-1:0]          ren_we,
  input  logic [REN_W-1:0][AW-1:0]  ren_src1,
  input  logic [REN_W-1:0][AW-1:0]  ren_src2,
  input  logic [REN_W-1:0][AW-1:0]  ren_dest,
  output logic [REN_W-1:0][PW-1:0]  ren_phy_src1,
  output logic [REN_W-1:0][PW-1:0]  ren_phy_src2,
  output logic [REN_W-1:0][PW-1:0]  ren_phy_dest,
  output logic [REN_W-1:0][PW-1:0]  ren_old_dest,
  input  logic [RET_W-1:0]          ret_valid,
  input  logic [RET_W-1:0][AW-1:0]  ret_dest,
  input  logic [RET_W-1:0][PW-1:0]  ret_phy_dest,
  input  logic [RET_W-1:0][PW-1:0]  ret_old_dest,
  output logic [PW:0]               free_count
);
  import rename_pkg::*;

  logic [PW-1:0] spec_map [ARCH_REGS];
  logic [PW-1:0] commit_map [ARCH_REGS];
  logic [PW-1:0] commit_nx [ARCH_REGS];
  logic [REN_W-1:0] weff;
  logic [CW-1:0] alloc_cnt;
  logic [REN_W-1:0][PW-1:0] peek;
  logic [RET_W-1:0] ret_commit;
  logic fire;

  // Writing lanes consume free-list entries in lane order.
  always_comb begin
    weff = '0;
    alloc_cnt = '0;
    ren_phy_dest = '0;
    for (int i = 0; i < REN_W; i++) begin
      weff[i] = ren_we[i] && (ren_dest[i] != '0);
      for (int k = 0; k < REN_W; k++) begin
        if (weff[i] && alloc_cnt == CW'(k)) begin
          ren_phy_dest[i] = peek[k];
        end
      end
      alloc_cnt = alloc_cnt + CW'(weff[i]);
    end
  end

  always_comb begin
    ren_phy_src1 = '0;
    ren_phy_src2 = '0;
    ren_old_dest = '0;
    for (int i = 0; i < REN_W; i++) begin
      ren_phy_src1[i] = spec_map[ren_src1[i]];
      ren_phy_src2[i] = spec_map[ren_src2[i]];
      ren_old_dest[i] = spec_map[ren_dest[i]];
      // Ascending scan lets the youngest older writer win.
      for (int j = 0; j < i; j++) begin
        if (weff[j] && ren_dest[j] == ren_src1[i])
          ren_phy_src1[i] = ren_phy_dest[j];
        if (weff[j] && ren_dest[j] == ren_src2[i])
          ren_phy_src2[i] = ren_phy_dest[j];
        if (weff[j] && ren_dest[j] == ren_dest[i])
          ren_old_dest[i] = ren_phy_dest[j];
      end
      if (ren_src1[i] == '0) ren_phy_src1[i] = '0;
      if (ren_src2[i] == '0) ren_phy_src2[i] = '0;
      if (ren_dest[i] == '0) ren_old_dest[i] = '0;
    end
  end

  assign ren_ready = !flush && (free_count >= (PW + 1)'(alloc_cnt));
  assign fire = ren_valid && ren_ready;

  always_comb begin
    commit_nx = commit_map;
    ret_commit = '0;
    for (int i = 0; i < RET_W; i++) begin
      ret_commit[i] = ret_valid[i] && (ret_dest[i] != '0);
      if (ret_commit[i]) begin
        commit_nx[ret_dest[i]] = ret_phy_dest[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int a = 0; a < ARCH_REGS; a++) begin
        spec_map[a] <= PW'(a);
        commit_map[a] <= PW'(a);
      end
    end else begin
      commit_map <= commit_nx;
      if (flush) begin
        spec_map <= commit_nx;
      end else if (fire) begin
        for (int i = 0; i < REN_W; i++) begin
          if (weff[i]) begin
            spec_map[ren_dest[i]] <= ren_phy_dest[i];
          end
        end
      end
    end
  end

  rename_freelist #(
    .ARCH_REGS (ARCH_REGS),
    .PHYS_REGS (PHYS_REGS),
    .REN_W     (REN_W),
    .RET_W     (RET_W)
  ) u_freelist (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .alloc        (fire),
    .alloc_cnt    (alloc_cnt),
    .ret_commit   (ret_commit),
    .ret_old_dest (ret_old_dest),
    .peek         (peek),
    .free_count   (free_count)
  );

endmodule

// File: tb/tb_rename_map.sv
// Bench for rename_map: vector table plus hand sequences,
// expectations queued at drive time and popped at sample time.
module tb_rename_map;
  import rename_pkg::*;

  typedef arch_reg_t [1:0] alane_t;
  typedef phys_reg_t [1:0] plane_t;
  typedef enum int {O_PS1, O_PS2, O_PD, O_OD, O_FC, O_RDY} obs_e;

  typedef struct {
    string name;
    obs_e  sel;
    int    lane;
    int    val;
  } exp_t;

  typedef struct {
    logic [1:0] we;
    alane_t s1, s2, d;
    plane_t ps1, ps2, pd, od;
    int fc;
  } vec_t;

  logic clk = 1'b0;
  logic resetn;
  logic flush;
  logic ren_valid;
  logic ren_ready;
  logic [1:0] ren_we;
  alane_t ren_src1, ren_src2, ren_dest;
  plane_t ren_phy_src1, ren_phy_src2;
  plane_t ren_phy_dest, ren_old_dest;
  logic [1:0] ret_valid;
  alane_t ret_dest;
  plane_t ret_phy_dest, ret_old_dest;
  fl_ptr_t free_count;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sbq[$];
  vec_t vt[7];

  always #5 clk = ~clk;

  rename_map dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .ren_valid    (ren_valid),
    .ren_ready    (ren_ready),
    .ren_we       (ren_we),
    .ren_src1     (ren_src1),
    .ren_src2     (ren_src2),
    .ren_dest     (ren_dest),
    .ren_phy_src1 (ren_phy_src1),
    .ren_phy_src2 (ren_phy_src2),
    .ren_phy_dest (ren_phy_dest),
    .ren_old_dest (ren_old_dest),
    .ret_valid    (ret_valid),
    .ret_dest     (ret_dest),
    .ret_phy_dest (ret_phy_dest),
    .ret_old_dest (ret_old_dest),
    .free_count   (free_count)
  );

  function automatic alane_t ap(input int l0, input int l1);
    alane_t r;
    r[0] = arch_reg_t'(l0);
    r[1] = arch_reg_t'(l1);
    return r;
  endfunction

  function automatic plane_t pp(input int l0, input int l1);
    plane_t r;
    r[0] = phys_reg_t'(l0);
    r[1] = phys_reg_t'(l1);
    return r;
  endfunction

  function automatic vec_t mk(
    input logic [1:0] we,
    input int a0, a1, b0, b1, d0, d1,
    input int p0, p1, q0, q1, x0, x1, o0, o1,
    input int fc
  );
    vec_t v;
    v.we = we;
    v.s1 = ap(a0, a1);
    v.s2 = ap(b0, b1);
    v.d = ap(d0, d1);
    v.ps1 = pp(p0, p1);
    v.ps2 = pp(q0, q1);
    v.pd = pp(x0, x1);
    v.od = pp(o0, o1);
    v.fc = fc;
    return v;
  endfunction

  // Free-list entry at position h after the one recycled push of r3.
  function automatic int ent(input int h);
    return (h < 30) ? 34 + h : 3;
  endfunction

  function automatic logic [31:0] obs(input obs_e s, input int l);
    case (s)
      O_PS1: return 32'(ren_phy_src1[l]);
      O_PS2: return 32'(ren_phy_src2[l]);
      O_PD:  return 32'(ren_phy_dest[l]);
      O_OD:  return 32'(ren_old_dest[l]);
      O_FC:  return 32'(free_count);
      default: return 32'(ren_ready);
    endcase
  endfunction

  task automatic expect_v(input string n, input obs_e s,
                          input int l, input int v);
    exp_t e;
    e.name = n;
    e.sel = s;
    e.lane = l;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [31:0] a;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = obs(e.sel, e.lane);
      n_cmp++;
      if (a !== e.val) begin
        n_err++;
        $display("FAIL %s: got %0d, want %0d", e.name, a, e.val);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] we,
                       input alane_t s1, input alane_t s2,
                       input alane_t d);
    ren_valid = v;
    ren_we = we;
    ren_src1 = s1;
    ren_src2 = s2;
    ren_dest = d;
  endtask

  task automatic retire(input logic [1:0] v, input alane_t d,
                        input plane_t p, input plane_t o);
    ret_valid = v;
    ret_dest = d;
    ret_phy_dest = p;
    ret_old_dest = o;
  endtask

  initial begin
    vt[0] = mk(2'b00, 5,0, 7,33, 0,0,  5,0, 7,33, 0,0, 0,0, 30);
    vt[1] = mk(2'b11, 1,3, 2,3, 3,3,   1,34, 2,34, 34,35, 3,34, 30);
    vt[2] = mk(2'b00, 3,4, 0,31, 0,0,  35,4, 0,31, 0,0, 0,0, 28);
    vt[3] = mk(2'b01, 0,0, 3,0, 0,0,   0,0, 35,0, 0,0, 0,0, 28);
    vt[4] = mk(2'b00, 0,3, 1,2, 0,0,   0,35, 1,2, 0,0, 0,0, 28);
    vt[5] = mk(2'b11, 10,10, 0,3, 10,10, 10,36, 0,35, 36,37, 10,36, 28);
    vt[6] = mk(2'b00, 10,3, 0,0, 0,0,  37,35, 0,0, 0,0, 0,0, 26);

    resetn = 1'b0;
    flush = 1'b0;
    drive(1'b0, 2'b00, '0, '0, '0);
    retire(2'b00, '0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    expect_v("reset_fc", O_FC, 0, 30);
    expect_v("reset_rdy", O_RDY, 0, 1);
    check_all();

    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      drive(1'b1, vt[k].we, vt[k].s1, vt[k].s2, vt[k].d);
      for (int l = 0; l < 2; l++) begin
        expect_v($sformatf("v%0d_ps1_%0d", k, l), O_PS1, l, int'(vt[k].ps1[l]));
        expect_v($sformatf("v%0d_ps2_%0d", k, l), O_PS2, l, int'(vt[k].ps2[l]));
        expect_v($sformatf("v%0d_pd_%0d", k, l), O_PD, l, int'(vt[k].pd[l]));
        expect_v($sformatf("v%0d_od_%0d", k, l), O_OD, l, int'(vt[k].od[l]));
      end
      expect_v($sformatf("v%0d_fc", k), O_FC, 0, vt[k].fc);
      expect_v($sformatf("v%0d_rdy", k), O_RDY, 0, 1);
      #1 check_all();
    end

    // Flush with nothing retired restores the identity map.
    @(negedge clk);
    drive(1'b0, 2'b00, '0, '0, '0);
    flush = 1'b1;
    #1;
    expect_v("flush_rdy", O_RDY, 0, 0);
    check_all();
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 2'b00, ap(3, 10), '0, '0);
    #1;
    expect_v("flush_r3", O_PS1, 0, 3);
    expect_v("flush_r10", O_PS1, 1, 10);
    expect_v("flush_fc", O_FC, 0, 30);
    check_all();

    // Retire and flush in the same cycle.
    @(negedge clk);
    flush = 1'b1;
    retire(2'b01, ap(3, 0), pp(34, 0), pp(3, 0));
    @(negedge clk);
    flush = 1'b0;
    retire(2'b00, '0, '0, '0);
    drive(1'b0, 2'b00, ap(3, 0), '0, '0);
    #1;
    expect_v("retflush_r3", O_PS1, 0, 34);
    expect_v("retflush_fc", O_FC, 0, 30);
    check_all();

    // Drain the free list; the last tag is the recycled r3 mapping.
    for (int g = 0; g < 15; g++) begin
      @(negedge clk);
      drive(1'b1, 2'b11, '0, '0, ap(11, 12));
      expect_v($sformatf("drain%0d_pd0", g), O_PD, 0, ent(1 + 2 * g));
      expect_v($sformatf("drain%0d_pd1", g), O_PD, 1, ent(2 + 2 * g));
      expect_v($sformatf("drain%0d_fc", g), O_FC, 0, 30 - 2 * g);
      expect_v($sformatf("drain%0d_rdy", g), O_RDY, 0, 1);
      #1 check_all();
    end
    @(negedge clk);
    drive(1'b1, 2'b01, '0, '0, ap(5, 0));
    #1;
    expect_v("empty_fc", O_FC, 0, 0);
    expect_v("empty_rdy_we", O_RDY, 0, 0);
    check_all();
    @(negedge clk);
    drive(1'b1, 2'b00, '0, '0, ap(5, 6));
    #1;
    expect_v("empty_rdy_nowe", O_RDY, 0, 1);
    check_all();
    @(negedge clk);
    drive(1'b1, 2'b01, '0, '0, ap(0, 0));
    #1;
    expect_v("empty_rdy_r0", O_RDY, 0, 1);
    expect_v("empty_fc2", O_FC, 0, 0);
    check_all();

    // Reset while a group is presented.
    @(negedge clk);
    drive(1'b1, 2'b11, ap(3, 3), '0, ap(3, 4));
    resetn = 1'b0;
    #1;
    expect_v("midrst_fc", O_FC, 0, 30);
    check_all();
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b0, 2'b00, ap(3, 11), '0, '0);
    #1;
    expect_v("midrst_r3", O_PS1, 0, 3);
    expect_v("midrst_r11", O_PS1, 1, 11);
    expect_v("midrst_fc2", O_FC, 0, 30);
    expect_v("midrst_rdy", O_RDY, 0, 1);
    check_all();

    // Fire and retire together, then flush back to committed state.
    @(negedge clk);
    drive(1'b1, 2'b01, '0, '0, ap(5, 0));
    retire(2'b11, ap(7, 8), pp(40, 41), pp(7, 0));
    #1;
    expect_v("fr_pd0", O_PD, 0, 34);
    expect_v("fr_rdy", O_RDY, 0, 1);
    check_all();
    @(negedge clk);
    drive(1'b0, 2'b00, '0, '0, '0);
    retire(2'b00, '0, '0, '0);
    #1;
    expect_v("fr_fc", O_FC, 0, 30);
    check_all();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 2'b00, ap(5, 7), ap(8, 0), '0);
    #1;
    expect_v("fr_r5", O_PS1, 0, 5);
    expect_v("fr_r7", O_PS1, 1, 40);
    expect_v("fr_r8", O_PS2, 0, 41);
    expect_v("fr_r0", O_PS2, 1, 0);
    expect_v("fr_fc2", O_FC, 0, 29);
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
